// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode and
// funct values, ALU control codes and datapath mux select codes.
// No logic or latency; constants only, so backpressure does not apply.
package mips_mc_pkg;

  // Encodings are visible on the State debug port, so they are pinned explicitly.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  // What the ALU is being used for in the current state.
  typedef enum logic [1:0] {
    ACLS_NONE,
    ACLS_ADD,
    ACLS_SUB,
    ACLS_FUNCT
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: maps the state's ALU usage class plus Funct to ALUCtr.
// Purely combinational, zero latency; no handshake, so no backpressure.
// Ports: cls_i (ALU usage class), funct_i (Instr[5:0]) -> alu_ctr_o, funct_bad_o.
module mc_alu_decoder
  import mips_mc_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctr_o,
  output logic       funct_bad_o
);

  logic [3:0] funct_alu;

  // funct_bad_o is valid whatever the class, so DECODE can use it directly.
  always_comb begin
    funct_alu   = ALU_ADD;
    funct_bad_o = 1'b0;
    case (funct_i)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_bad_o = 1'b1;
    endcase
  end

  // States that do not use the ALU drive all-zero (the AND code).
  always_comb begin
    alu_ctr_o = ALU_AND;
    case (cls_i)
      ACLS_NONE:  alu_ctr_o = ALU_AND;
      ACLS_ADD:   alu_ctr_o = ALU_ADD;
      ACLS_SUB:   alu_ctr_o = ALU_SUB;
      ACLS_FUNCT: alu_ctr_o = funct_alu;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the multicycle MIPS datapath (PC/IR/A/B/ALUOut/MDR).
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles, +1 per cycle of MemRdy=0.
// Backpressure: FETCH, MEMRD and MEMWR hold with requests asserted until MemRdy.
// Ports: Clk, Reset (async, active-low); Op/Funct from IR, Zero from ALU,
// MemRdy from memory; mux selects, write enables, Illegal pulse, State debug.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemRdy,
  output logic               PCWr,
  output logic               IorD,
  output logic               MemRd,
  output logic               MemWr,
  output logic               IRWr,
  output logic               RegDst,
  output logic               Mem2Reg,
  output logic               RegWr,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUCtr,
  output logic [1:0]         PCSrc,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  state_e   state_q, state_d;
  logic     illegal_q, illegal_d;
  alu_cls_e alu_cls;
  logic     funct_bad;
  logic     pcwr_c, irwr_c, memrd_c, memwr_c, regwr_c;

  mc_alu_decoder u_alu_dec (
    .cls_i       (alu_cls),
    .funct_i     (Funct),
    .alu_ctr_o   (ALUCtr),
    .funct_bad_o (funct_bad)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  if (MemRdy) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_RTYPE: begin
            if (funct_bad) begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end else begin
              state_d = S_EXEC;
            end
          end
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemRdy) state_d = S_MEMWB;
      S_MEMWR:  if (MemRdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;  // write-backs, BRANCH, JUMP, unused codes
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs decode the registered state only, except the MemRdy gating in
  // FETCH and Zero in BRANCH.
  always_comb begin
    pcwr_c  = 1'b0;
    irwr_c  = 1'b0;
    memrd_c = 1'b0;
    memwr_c = 1'b0;
    regwr_c = 1'b0;
    IorD    = 1'b0;
    RegDst  = 1'b0;
    Mem2Reg = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_B;
    PCSrc   = PCSRC_ALU;
    alu_cls = ACLS_NONE;
    case (state_q)
      S_FETCH: begin
        memrd_c = 1'b1;
        ALUSrcB = SRCB_4;
        alu_cls = ACLS_ADD;
        PCSrc   = PCSRC_ALU;
        // PC and IR only advance once the instruction word is actually back.
        irwr_c  = MemRdy;
        pcwr_c  = MemRdy;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BR;
        alu_cls = ACLS_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_cls = ACLS_ADD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        memrd_c = 1'b1;
      end
      S_MEMWB: begin
        Mem2Reg = 1'b1;
        regwr_c = 1'b1;
      end
      S_MEMWR: begin
        IorD    = 1'b1;
        memwr_c = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        alu_cls = ACLS_FUNCT;
      end
      S_RWB: begin
        RegDst  = 1'b1;
        regwr_c = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_cls = ACLS_SUB;
        PCSrc   = PCSRC_OUT;
        pcwr_c  = Zero;
      end
      S_JUMP: begin
        PCSrc  = PCSRC_JMP;
        pcwr_c = 1'b1;
      end
      S_ADDIWB: regwr_c = 1'b1;
      default: ;
    endcase
  end

  // Enables are masked by Reset so an abandoned access cannot complete.
  assign PCWr    = Reset & pcwr_c;
  assign IRWr    = Reset & irwr_c;
  assign MemRd   = Reset & memrd_c;
  assign MemWr   = Reset & memwr_c;
  assign RegWr   = Reset & regwr_c;
  assign Illegal = illegal_q;
  assign State   = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemRdy = 1'b1;
  logic       PCWr, IorD, MemRd, MemWr, IRWr, RegDst, Mem2Reg, RegWr, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUCtr;
  logic [3:0] State;

  always #5 Clk = ~Clk;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemRdy(MemRdy),
    .PCWr(PCWr), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr), .IRWr(IRWr),
    .RegDst(RegDst), .Mem2Reg(Mem2Reg), .RegWr(RegWr), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUCtr(ALUCtr), .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
  );

  // Phase numbers as they appear on the State port.
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
  localparam int EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, RT = 6'b000000;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwr, iord, memrd, memwr, irwr, regdst, mem2reg, regwr, srca;
    logic [1:0] srcb;
    logic [3:0] aluctr;
    logic [1:0] pcsrc;
    logic       illegal;
  } ctl_t;

  ctl_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic ill_pending = 1'b0;
  logic [5:0] good_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn);
    return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
           (fn == 6'b100101) || (fn == 6'b101010);
  endfunction

  function automatic bit op_ok(input logic [5:0] op);
    return (op == RT) || (op == LW) || (op == SW) || (op == BEQ) || (op == ADDI) || (op == J);
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Control word the datapath should see in a given phase (unlisted outputs 0).
  function automatic ctl_t ref_out(input int st, input logic rdy, input logic z,
                                   input logic [5:0] fn, input logic ill);
    ctl_t e;
    e = '0;
    e.st = 4'(st);
    e.illegal = ill;
    case (st)
      FETCH:  begin e.memrd = 1; e.srcb = 2'b01; e.aluctr = 4'b0010; e.irwr = rdy; e.pcwr = rdy; end
      DECODE: begin e.srcb = 2'b11; e.aluctr = 4'b0010; end
      MEMADR, ADDIEX: begin e.srca = 1; e.srcb = 2'b10; e.aluctr = 4'b0010; end
      MEMRD:  begin e.iord = 1; e.memrd = 1; end
      MEMWB:  begin e.mem2reg = 1; e.regwr = 1; end
      MEMWR:  begin e.iord = 1; e.memwr = 1; end
      EXEC:   begin e.srca = 1; e.aluctr = funct_alu(fn); end
      RWB:    begin e.regdst = 1; e.regwr = 1; end
      BRANCH: begin e.srca = 1; e.aluctr = 4'b0110; e.pcsrc = 2'b01; e.pcwr = z; end
      JUMP:   begin e.pcsrc = 2'b10; e.pcwr = 1; end
      ADDIWB: begin e.regwr = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected control word, advance.
  task automatic step(input int st, input logic rdy, input logic z, input logic ill);
    MemRdy = rdy;
    Zero   = z;
    exp_q.push_back(ref_out(st, rdy, z, Funct, ill));
    @(posedge Clk);
    #1;
  endtask

  // Instruction-level model: phase list from the opcode, waits from the memory.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    logic ill;
    ill = ill_pending;
    ill_pending = 1'b0;
    Op = op;
    Funct = fn;
    for (int i = 0; i < fw; i++) begin
      step(FETCH, 1'b0, rb(), ill);
      ill = 1'b0;
    end
    step(FETCH, 1'b1, rb(), ill);
    step(DECODE, rb(), rb(), 1'b0);
    if (op == LW) begin
      step(MEMADR, rb(), rb(), 1'b0);
      for (int i = 0; i < mw; i++) step(MEMRD, 1'b0, rb(), 1'b0);
      step(MEMRD, 1'b1, rb(), 1'b0);
      step(MEMWB, rb(), rb(), 1'b0);
    end else if (op == SW) begin
      step(MEMADR, rb(), rb(), 1'b0);
      for (int i = 0; i < mw; i++) step(MEMWR, 1'b0, rb(), 1'b0);
      step(MEMWR, 1'b1, rb(), 1'b0);
    end else if (op == RT && funct_ok(fn)) begin
      step(EXEC, rb(), rb(), 1'b0);
      step(RWB, rb(), rb(), 1'b0);
    end else if (op == BEQ) begin
      step(BRANCH, rb(), z, 1'b0);
    end else if (op == J) begin
      step(JUMP, rb(), rb(), 1'b0);
    end else if (op == ADDI) begin
      step(ADDIEX, rb(), rb(), 1'b0);
      step(ADDIWB, rb(), rb(), 1'b0);
    end else begin
      ill_pending = 1'b1;
    end
  endtask

  // Monitor: every cycle out of reset with an expectation queued is compared.
  always @(negedge Clk) begin
    ctl_t e, a;
    if (Reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {State, PCWr, IorD, MemRd, MemWr, IRWr, RegDst, Mem2Reg, RegWr, ALUSrcA,
           ALUSrcB, ALUCtr, PCSrc, Illegal};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctl_word t=%0t: got state=%0d word=%h, expected state=%0d word=%h",
                 $time, a.st, a, e.st, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int kind;
    #3;
    chk("reset_state", int'(State), 0);
    chk("reset_enables", int'({PCWr, IRWr, MemRd, MemWr, RegWr, Illegal}), 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;

    run_instr(LW, 6'd0, 1'b0, 0, 0);
    run_instr(SW, 6'd0, 1'b0, 0, 3);
    run_instr(BEQ, 6'd0, 1'b1, 0, 0);
    run_instr(BEQ, 6'd0, 1'b0, 0, 0);
    run_instr(RT, 6'b101010, 1'b0, 0, 0);
    run_instr(RT, 6'b000111, 1'b0, 0, 0);
    run_instr(J, 6'd0, 1'b0, 2, 0);
    run_instr(ADDI, 6'd0, 1'b0, 1, 0);

    // Reset asserted mid-store while MemWr is high.
    Op = SW;
    Funct = 6'd0;
    step(FETCH, 1'b1, 1'b0, 1'b0);
    step(DECODE, 1'b1, 1'b0, 1'b0);
    step(MEMADR, 1'b1, 1'b0, 1'b0);
    MemRdy = 1'b0;
    exp_q.push_back(ref_out(MEMWR, 1'b0, 1'b0, Funct, 1'b0));
    @(negedge Clk);
    #2;
    chk("memwr_before_reset", int'(MemWr), 1);
    Reset = 1'b0;
    #1;
    chk("memwr_async_drop", int'(MemWr), 0);
    chk("state_async_fetch", int'(State), 0);
    chk("enables_in_reset", int'({PCWr, IRWr, MemRd, MemWr, RegWr, Illegal}), 0);
    @(posedge Clk);
    #1;
    chk("state_held_in_reset", int'(State), 0);
    Reset = 1'b1;
    ill_pending = 1'b0;
    run_instr(LW, 6'd0, 1'b0, 0, 1);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 8);
      fn = good_fn[$urandom_range(0, 4)];
      case (kind)
        0: op = LW;
        1: op = SW;
        3: op = BEQ;
        4: op = ADDI;
        5: op = J;
        6: begin
          op = 6'($urandom_range(0, 63));
          while (op_ok(op)) op = 6'($urandom_range(0, 63));
        end
        7: begin
          op = RT;
          fn = 6'($urandom_range(0, 63));
          while (funct_ok(fn)) fn = 6'($urandom_range(0, 63));
        end
        default: op = RT;
      endcase
      run_instr(op, fn, rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                $urandom_range(0, 3));
    end

    @(posedge Clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
